// File: rtl/spdif_subframe_encoder.sv
// S/PDIF sub-frame encoder: one 24-bit word in, 64 biphase-mark half-cells out.
// Ports: clk128/reset, i_valid/i_ready word handshake, word fields, spdif line.
module spdif_subframe_encoder (
  input  logic        clk128,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        i_is_frame_start,
  input  logic        i_is_left,
  input  logic [23:0] i_audio,
  input  logic        i_user,
  input  logic        i_control,
  output logic        spdif
);

  typedef struct packed {
    logic [23:0] audio;
    logic        user;
    logic        control;
    logic        start;
    logic        left;
  } word_t;

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  word_t       hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  pre_q, pre_d;
  logic        spdif_q, spdif_d;

  logic        accept;
  logic        par;
  logic [7:0]  pat;
  word_t       in_word;

  assign i_ready = ~hold_full_q;
  assign spdif   = spdif_q;
  assign accept  = i_valid & ~hold_full_q;

  assign in_word = '{
    audio:   i_audio,
    user:    i_user,
    control: i_control,
    start:   i_is_frame_start,
    left:    i_is_left
  };

  // V is always 0, so parity covers audio, U and C only.
  assign par = ^{hold_q.audio, hold_q.user, hold_q.control};

  always_comb begin
    pat = PRE_W;
    unique case (1'b1)
      hold_q.start:                pat = PRE_B;
      ~hold_q.start & hold_q.left:  pat = PRE_M;
      ~hold_q.start & ~hold_q.left: pat = PRE_W;
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    pre_d       = pre_q;
    spdif_d     = spdif_q;

    if (cnt_q != 6'd0) begin
      cnt_d = cnt_q + 6'd1;
      if (cnt_q < 6'd8) begin
        spdif_d = pre_q[3'd7 - cnt_q[2:0]];
      end else if (!cnt_q[0]) begin
        spdif_d = ~spdif_q;
      end else begin
        // Slot index is cnt/2; data_q holds slots 0..31 (0..3 unused).
        spdif_d = spdif_q ^ data_q[cnt_q[5:1]];
      end
    end else if (hold_full_q) begin
      // Preamble is stored pre-inverted for the current line level.
      pre_d       = pat ^ {8{spdif_q}};
      data_d      = {par, hold_q.control, hold_q.user, 1'b0,
                     hold_q.audio, 4'b0000};
      spdif_d     = pat[7] ^ spdif_q;
      cnt_d       = 6'd1;
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_d      = in_word;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk128 or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= 6'd0;
      data_q      <= '0;
      pre_q       <= '0;
      spdif_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      pre_q       <= pre_d;
      spdif_q     <= spdif_d;
    end
  end

endmodule

// File: tb/tb_spdif_subframe_encoder.sv
// Bench for spdif_subframe_encoder: random words vs a queue-based line model.
// Each completed sub-frame is also decoded from the observed line.
module tb_spdif_subframe_encoder;

  typedef struct packed {
    logic [23:0] audio;
    logic        user;
    logic        control;
    logic        start;
    logic        left;
  } wd_t;

  logic        clk128 = 1'b0;
  logic        reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic        i_is_frame_start = 1'b0;
  logic        i_is_left = 1'b0;
  logic [23:0] i_audio = '0;
  logic        i_user = 1'b0;
  logic        i_control = 1'b0;
  logic        spdif;

  int checks = 0;
  int errors = 0;

  spdif_subframe_encoder dut (
    .clk128           (clk128),
    .reset            (reset),
    .i_valid          (i_valid),
    .i_ready          (i_ready),
    .i_is_frame_start (i_is_frame_start),
    .i_is_left        (i_is_left),
    .i_audio          (i_audio),
    .i_user           (i_user),
    .i_control        (i_control),
    .spdif            (spdif)
  );

  always #5 clk128 = ~clk128;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pre_of(input wd_t w);
    if (w.start) return 8'hE8;
    if (w.left) return 8'hE2;
    return 8'hE4;
  endfunction

  // Full 64 half-cell sequence (cell 0 in bit 0) from a start level.
  function automatic logic [63:0] gen(input wd_t w, input logic lvl);
    logic [63:0] c;
    logic [7:0]  p;
    logic [27:0] b;
    logic        l;
    int          ones;
    c = '0;
    p = pre_of(w);
    for (int i = 0; i < 8; i++) c[i] = p[7-i] ^ lvl;
    b = '0;
    b[23:0] = w.audio;
    b[24] = 1'b0;
    b[25] = w.user;
    b[26] = w.control;
    ones = 0;
    for (int k = 0; k < 27; k++) ones += int'(b[k]);
    b[27] = (ones % 2) == 1;
    l = c[7];
    for (int k = 0; k < 28; k++) begin
      l = ~l;
      c[8+2*k] = l;
      if (b[k]) l = ~l;
      c[9+2*k] = l;
    end
    return c;
  endfunction

  wd_t         m_word, m_cur;
  logic        m_full, m_lvl, m_start_lvl;
  logic [63:0] m_cells;
  int          m_pos, m_last;
  bit          m_acc;
  logic [63:0] obs;

  always @(posedge clk128 or negedge reset) begin
    if (!reset) begin
      m_full = 1'b0;
      m_lvl  = 1'b0;
      m_pos  = 0;
      m_last = -1;
      m_acc  = 1'b0;
    end else begin
      m_acc = i_valid && !m_full;
      if (m_pos != 0) begin
        m_lvl  = m_cells[m_pos];
        m_last = m_pos;
        m_pos  = (m_pos + 1) % 64;
      end else if (m_full) begin
        m_start_lvl = m_lvl;
        m_cells = gen(m_word, m_lvl);
        m_cur  = m_word;
        m_lvl  = m_cells[0];
        m_last = 0;
        m_pos  = 1;
        m_full = 1'b0;
      end else begin
        m_last = -1;
      end
      if (m_acc) begin
        m_full = 1'b1;
        m_word = '{audio: i_audio, user: i_user, control: i_control,
                   start: i_is_frame_start, left: i_is_left};
      end
    end
  end

  task automatic decode();
    logic [7:0]  p;
    logic [23:0] a;
    int          ones;
    p = '0;
    for (int i = 0; i < 8; i++) p[7-i] = obs[i] ^ m_start_lvl;
    check("preamble", {24'd0, p}, {24'd0, pre_of(m_cur)});
    a = '0;
    for (int k = 0; k < 24; k++) a[k] = obs[8+2*k] ^ obs[9+2*k];
    check("audio", {8'd0, a}, {8'd0, m_cur.audio});
    check("vbit", {31'd0, obs[56] ^ obs[57]}, 32'd0);
    check("ubit", {31'd0, obs[58] ^ obs[59]}, {31'd0, m_cur.user});
    check("cbit", {31'd0, obs[60] ^ obs[61]}, {31'd0, m_cur.control});
    ones = 0;
    for (int s = 4; s < 32; s++) ones += int'(obs[2*s] ^ obs[2*s+1]);
    check("parity", ones % 2, 0);
  endtask

  always @(negedge clk128) begin
    if (reset) begin
      check("spdif", {31'd0, spdif}, {31'd0, m_lvl});
      check("ready", {31'd0, i_ready}, {31'd0, ~m_full});
      if (m_last >= 0) begin
        obs[m_last] = spdif;
        if (m_last == 63) decode();
      end
    end
  end

  task automatic scramble();
    i_audio          = 24'($urandom);
    i_user           = 1'($urandom);
    i_control        = 1'($urandom);
    i_is_frame_start = 1'($urandom);
    i_is_left        = 1'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 of the accept edge.
  task automatic send(input logic [23:0] a, input logic st,
                      input logic lf, input logic u, input logic c);
    bit got;
    i_audio          = a;
    i_is_frame_start = st;
    i_is_left        = lf;
    i_user           = u;
    i_control        = c;
    i_valid          = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(posedge clk128);
      #1;
      if (m_acc) got = 1'b1;
    end
    i_valid = 1'b0;
    scramble();
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk128);
    #1;
  endtask

  task automatic send_rand();
    send(24'($urandom), ($urandom_range(0, 7) == 0),
         1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    bit hit;
    repeat (3) begin
      @(negedge clk128);
      check("rst_spdif", {31'd0, spdif}, 32'd0);
      check("rst_ready", {31'd0, i_ready}, 32'd1);
    end
    reset = 1'b1;
    idle(6);

    send(24'hFFFFF8, 1'b1, 1'b1, 1'b1, 1'b1);
    send(24'h123456, 1'b0, 1'b0, 1'b0, 1'b0);
    send(24'h987655, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(150);

    send(24'hA5A5A5, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(100);

    for (int it = 0; it < 40; it++) begin
      idle($urandom_range(0, 80));
      send_rand();
    end
    idle(140);

    send(24'h0F0F0F, 1'b0, 1'b1, 1'b0, 1'b1);
    send(24'h00FF00, 1'b0, 1'b0, 1'b1, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk128);
      #1;
      if (m_last == 30) hit = 1'b1;
    end
    if (!hit) check("mid_timeout", 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_spdif", {31'd0, spdif}, 32'd0);
    check("abort_ready", {31'd0, i_ready}, 32'd1);
    @(negedge clk128);
    check("abort_hold", {31'd0, spdif}, 32'd0);
    reset = 1'b1;
    idle(3);
    send(24'h5A5A5A, 1'b1, 1'b0, 1'b1, 1'b1);
    send_rand();
    idle(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spdif_subframe_encoder.md
Name: spdif_subframe_encoder

Overview:
- Serialises one S/PDIF (IEC 60958) sub-frame per accepted input word into a biphase-mark line signal.
- Clocked at 128×fs, so each clock emits one half-cell and one 32-slot sub-frame takes exactly 64 clocks.
- Sits between the frame sequencer, which supplies samples and channel/U/C bits over a valid/ready handshake, and the S/PDIF output pin.

Parameters:
none

Ports:
clk128  in  1  128×fs clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
i_valid  in  1  input word valid
i_ready  out  1  encoder can accept a word; transfer on rising edge when i_valid & i_ready
i_is_frame_start  in  1  sub-frame starts a 192-frame block (B preamble)
i_is_left  in  1  1 = left/channel A, 0 = right/channel B
i_audio  in  24  sample, sent LSB first
i_user  in  1  U bit
i_control  in  1  C (channel status) bit
spdif  out  1  registered biphase-mark output

Behaviour:
- Reset state (reset low, asynchronous): spdif=0, holding register empty, i_ready=1, serializer idle, cell counter cnt=0.
- Holding register: one entry capturing audio, U, C, frame_start, left on an accepted transfer.
  - i_ready = ~hold_full, driven from the register with no combinational path from i_valid.
  - i_valid while i_ready=0 is ignored; the word stays pending at the source.
- Sub-frame layout (time slots):
  - 0-3: preamble, 8 half-cells.
  - 4-27: audio bits 0..23.
  - 28: V=0.
  - 29: U.
  - 30: C.
  - 31: P, chosen so slots 4-31 contain an even number of ones.
- Preamble selection:
  - i_is_frame_start=1 → B; i_is_left is ignored.
  - else i_is_left=1 → M.
  - else W.
- Preamble patterns when the current line level is 0: B=11101000, M=11100010, W=11100100. When the current level is 1, send the bitwise complement.
- Data slots (4-31), biphase mark: the first half-cell always inverts the previous level; the second half-cell inverts again only if the bit is 1.
- Sequencing; cnt (6 bits) is the index of the next half-cell to emit:
  - Each edge with cnt≠0: spdif ← cell[cnt]; cnt ← cnt+1, wrapping 63→0.
  - Each edge with cnt=0 and hold_full=1: load the serializer from the holding register; spdif ← cell[0]; cnt ← 1; hold_full ← 0, so i_ready rises after that edge.
  - Each edge with cnt=0 and hold_full=0 (idle or underrun): spdif holds its level, serializer idles, no partial sub-frame.
- Timing:
  - Latency: word accepted at edge T while idle → cell 0 on spdif after edge T+1.
  - Consecutive sub-frames are gap-free if the next word is accepted before the serializer's cnt=0 edge.
  - A word is accepted at most once per sub-frame period during continuous streaming, because the holding register frees only at the load edge.
- Reset mid-sub-frame aborts immediately: line forced to 0, pending word discarded.
- An accept and a load never happen on the same edge with the same slot. An accept is only possible when the holding register is empty; a load requires it full.

Test Plan:
- Reset, then hold: spdif=0 and i_ready=1 throughout; no edges on spdif.
- Sub-frame audio=FFFFF8, frame_start=1, left=1, U=1, C=1 → B preamble 11101000 (from level 0).
  - Data LSB first: 0,0,0 then 21 ones; V=0, U=1, C=1, P=1.
  - Decoded sample equals FFFFF8; 64 half-cells total.
- Back-to-back: audio=123456, frame_start=0, left=0, U=C=0 accepted during the previous sub-frame → W preamble (complemented if level 1) directly after cell 63.
  - P=1 (9 ones); decoded value 123456; no gap.
- audio=987655, frame_start=0, left=1 → M preamble; P=0 (12 ones); decoded 987655.
- Underrun: no word offered at the boundary → spdif constant after the last cell.
  - The next word is accepted at edge T; cell 0 appears after edge T+1.
- Handshake: i_valid held through a busy sub-frame → i_ready low while the holding register is full.
  - Exactly one transfer per word; the word is not duplicated or lost.
- Reset asserted at cnt≈30 → spdif=0 immediately; i_ready=1 after release; the first new word is encoded correctly.
